fetch_unit: RTL

Instruction fetch stage between the program-counter generator and the decoder of the 8-bit CPU. Each cycle it presents the current PC to the synchronous instruction ROM and collects the returned bytes. It assembles one- or two-byte instructions and hands each completed instruction to decode as a one-cycle valid pulse. When decode redirects the PC, it squashes the wrong-path bytes still in flight. There is no backpressure, because the PC advances every clock.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the 8-bit CPU.
// Drives the synchronous ROM address straight from the PC, tracks whether the
// returning byte is on-path, and assembles one- or two-byte instructions into
// single-cycle valid pulses for decode. A branch squashes the byte in flight and
// the byte whose address is being presented, and discards any half-built
// instruction. No backpressure: the PC advances every clock.
module fetch_unit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] pc_i,
  input  logic       branch_en_i,
  output logic [7:0] imem_addr_o,
  input  logic [7:0] imem_data_i,
  output logic       instr_valid_o,
  output logic [7:0] instr_op_o,
  output logic [7:0] instr_imm_o,
  output logic [7:0] instr_pc_o
);

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_t;

  // Assembly state
  state_t     state_q, state_d;
  logic [7:0] op_hold_q, op_hold_d;
  logic [7:0] pc_hold_q, pc_hold_d;

  // Path tracking for the address on pc_i and the byte on imem_data_i
  logic       addr_vld_q, addr_vld_d;
  logic       data_vld_q, data_vld_d;
  logic [7:0] data_pc_q, data_pc_d;

  // Registered decode-facing outputs
  logic       valid_q, valid_d;
  logic [7:0] op_q, op_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] ipc_q, ipc_d;

  // A byte is only used when it is on-path and not squashed by a branch this cycle
  logic       consume;
  logic       byte_two;

  assign imem_addr_o   = pc_i;
  assign instr_valid_o = valid_q;
  assign instr_op_o    = op_q;
  assign instr_imm_o   = imm_q;
  assign instr_pc_o    = ipc_q;

  assign consume  = data_vld_q & ~branch_en_i;
  assign byte_two = imem_data_i[7];

  // Next-state: path tracking, instruction assembly and output pulse generation
  always_comb begin
    state_d    = state_q;
    op_hold_d  = op_hold_q;
    pc_hold_d  = pc_hold_q;
    op_d       = op_q;
    imm_d      = imm_q;
    ipc_d      = ipc_q;
    valid_d    = 1'b0;

    // The address presented now becomes the data address next cycle; a branch
    // this cycle means the address on pc_i is wrong-path.
    data_pc_d  = pc_i;
    data_vld_d = addr_vld_q & ~branch_en_i;
    addr_vld_d = 1'b1;

    if (branch_en_i) begin
      // Redirect: drop the in-flight byte and any partially built instruction.
      state_d = S_OP;
    end else if (consume) begin
      unique case (state_q)
        S_OP: begin
          if (byte_two) begin
            op_hold_d = imem_data_i;
            pc_hold_d = data_pc_q;
            state_d   = S_IMM;
          end else begin
            op_d    = imem_data_i;
            imm_d   = 8'h00;
            ipc_d   = data_pc_q;
            valid_d = 1'b1;
          end
        end
        S_IMM: begin
          op_d    = op_hold_q;
          imm_d   = imem_data_i;
          ipc_d   = pc_hold_q;
          valid_d = 1'b1;
          state_d = S_OP;
        end
        default: begin
          state_d = S_OP;
        end
      endcase
    end
  end

  // State and output registers; reset takes effect immediately without a clock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_OP;
      op_hold_q  <= 8'h00;
      pc_hold_q  <= 8'h00;
      addr_vld_q <= 1'b1;
      data_vld_q <= 1'b0;
      data_pc_q  <= 8'h00;
      valid_q    <= 1'b0;
      op_q       <= 8'h00;
      imm_q      <= 8'h00;
      ipc_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      op_hold_q  <= op_hold_d;
      pc_hold_q  <= pc_hold_d;
      addr_vld_q <= addr_vld_d;
      data_vld_q <= data_vld_d;
      data_pc_q  <= data_pc_d;
      valid_q    <= valid_d;
      op_q       <= op_d;
      imm_q      <= imm_d;
      ipc_q      <= ipc_d;
    end
  end

endmodule
